// File: rtl/tkx_unload_32b_pkg.sv
// Shared widths and state encoding for the 128-to-32 tweakey unloader.
package tkx_unload_32b_pkg;

  localparam int WORD_W = 32;
  localparam int BLK_W  = 128;
  localparam int WORDS  = 4;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage

// File: rtl/tkx_unload_32b.sv
// Serializes a 128-bit tweakey/state word into four 32-bit words, MSW first.
// Output side is registered; ld_ready may follow do_ready for zero-bubble reloads.
module tkx_unload_32b
  import tkx_unload_32b_pkg::*;
#(
  parameter int CLEAR_ON_DONE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [BLK_W-1:0]  ld_data,
  output logic              ld_ready,
  input  logic              flush,
  output logic [WORD_W-1:0] do_data,
  output logic              do_valid,
  input  logic              do_ready,
  output logic              do_last,
  output logic              busy
);

  localparam logic [1:0] LAST_CNT = 2'(WORDS - 1);

  state_e             state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [BLK_W-1:0]   sr_q, sr_d;
  logic               is_send;
  logic               at_last;
  logic               load_go;
  logic               xfer;
  logic               clr;

  assign is_send = (state_q == SEND);
  assign at_last = (cnt_q == LAST_CNT);
  assign clr     = (CLEAR_ON_DONE != 0);

  assign ld_ready = !flush &&
                    (!is_send || (at_last && do_ready));
  assign load_go  = ld_valid && ld_ready;
  assign xfer     = is_send && do_ready &&
                    !flush && !load_go;

  assign do_valid = is_send;
  assign do_data  = is_send ? sr_q[BLK_W-1 -: WORD_W]
                            : '0;
  assign do_last  = is_send && at_last;
  assign busy     = is_send;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    unique case (1'b1)
      flush: begin
        state_d = IDLE;
        cnt_d   = '0;
        if (clr) sr_d = '0;
      end
      load_go: begin
        state_d = SEND;
        cnt_d   = '0;
        sr_d    = ld_data;
      end
      xfer: begin
        if (at_last) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (clr) sr_d = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
          sr_d  = {sr_q[BLK_W-WORD_W-1:0],
                   {WORD_W{1'b0}}};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

endmodule

// File: tb/tb_tkx_unload_32b.sv
// Bench for tkx_unload_32b: scoreboarded word stream,
// stall, back-to-back, flush, async reset and loopback.
module tb_tkx_unload_32b;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  localparam logic [127:0] V =
    128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] A =
    128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] B =
    128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] JUNK =
    128'hA5A5A5A5_5A5A5A5A_F0F0F0F0_0F0F0F0F;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld_valid;
  logic [127:0] ld_data;
  logic         ld_ready;
  logic         flush;
  logic [31:0]  do_data;
  logic         do_valid;
  logic         do_ready;
  logic         do_last;
  logic         busy;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;

  tkx_unload_32b #(.CLEAR_ON_DONE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .flush    (flush),
    .do_data  (do_data),
    .do_valid (do_valid),
    .do_ready (do_ready),
    .do_last  (do_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic push_blk(input logic [127:0] v);
    exp_t x;
    for (int i = 0; i < 4; i++) begin
      x.d = v[127-32*i -: 32];
      x.l = (i == 3);
      q.push_back(x);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; ld_valid = 1'b0; ld_data = '0;
    flush = 1'b0; do_ready = 1'b0;
    #3;
    n_chk++;
    if ({do_valid, do_data, do_last, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got v%b d%h l%b b%b want all 0",
               do_valid, do_data, do_last, busy);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ld_ready: got %b want 1", ld_ready);
    end
  endtask

  task automatic test_stream();
    @(posedge clk); #1;
    do_ready = 1'b1; ld_valid = 1'b1; ld_data = V;
    push_blk(V);
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stream_latency: got v%b r%b want v0 r1",
               do_valid, ld_ready);
    end
    @(posedge clk); #1 ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      if (do_valid !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_valid[%0d]: got %b want 1", i, do_valid);
      end else begin
        e = q.pop_front();
        if (do_data !== e.d || do_last !== e.l) begin
          n_fail++;
          $display("FAIL stream_word[%0d]: got %h/%b want %h/%b",
                   i, do_data, do_last, e.d, e.l);
        end
      end
    end
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || busy !== 1'b0 || do_data !== 32'd0) begin
      n_fail++;
      $display("FAIL stream_end: got v%b b%b d%h want 0/0/0",
               do_valid, busy, do_data);
    end
  endtask

  task automatic test_stall();
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    @(posedge clk); #1;
    do_ready = 1'b1; ld_valid = 1'b1; ld_data = V;
    push_blk(V);
    @(posedge clk); #1 ld_valid = 1'b0;
    for (int c = 0; c < 7; c++) begin
      do_ready = pat[c];
      @(negedge clk);
      n_chk++;
      if (do_valid !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL stall_valid[%0d]: got %b want 1", c, do_valid);
      end else if (do_ready) begin
        e = q.pop_front();
        if (do_data !== e.d || do_last !== e.l) begin
          n_fail++;
          $display("FAIL stall_word[%0d]: got %h/%b want %h/%b",
                   c, do_data, do_last, e.d, e.l);
        end
      end else if (do_data !== q[0].d || do_last !== q[0].l) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h/%b want %h/%b",
                 c, do_data, do_last, q[0].d, q[0].l);
      end
      @(posedge clk); #1;
    end
    do_ready = 1'b1;
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_end: got v%b left %0d want v0 left 0",
               do_valid, q.size());
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    do_ready = 1'b1; ld_valid = 1'b1; ld_data = A;
    push_blk(A);
    @(posedge clk); #1;
    for (int c = 0; c < 8; c++) begin
      ld_valid = (c == 1 || c == 3);
      ld_data  = (c == 3) ? B : JUNK;
      if (c == 3) push_blk(B);
      @(negedge clk);
      if (c == 1) begin
        n_chk++;
        if (ld_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_ignore_ld: got %b want 0", ld_ready);
        end
      end
      if (c == 3) begin
        n_chk++;
        if (ld_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ld_ready: got %b want 1", ld_ready);
        end
      end
      n_chk++;
      if (do_valid !== 1'b1 || q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_gap[%0d]: got %b want 1", c, do_valid);
      end else begin
        e = q.pop_front();
        if (do_data !== e.d || do_last !== e.l) begin
          n_fail++;
          $display("FAIL b2b_word[%0d]: got %h/%b want %h/%b",
                   c, do_data, do_last, e.d, e.l);
        end
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_end: got v%b left %0d want v0 left 0",
               do_valid, q.size());
    end
  endtask

  task automatic test_flush();
    @(posedge clk); #1;
    do_ready = 1'b1; ld_valid = 1'b1; ld_data = V;
    push_blk(V);
    @(posedge clk); #1;
    for (int c = 0; c < 4; c++) begin
      flush    = (c == 2);
      ld_valid = (c == 2);
      ld_data  = JUNK;
      @(negedge clk);
      if (c < 2) begin
        n_chk++;
        e = q.pop_front();
        if (do_valid !== 1'b1 || do_data !== e.d) begin
          n_fail++;
          $display("FAIL flush_pre[%0d]: got %b/%h want 1/%h",
                   c, do_valid, do_data, e.d);
        end
      end else if (c == 2) begin
        n_chk++;
        if (ld_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL flush_ld_ready: got %b want 0", ld_ready);
        end
      end else begin
        n_chk++;
        if (do_valid !== 1'b0 || busy !== 1'b0 ||
            do_data !== 32'd0 || ld_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL flush_after: got v%b b%b d%h r%b want 0/0/0/1",
                   do_valid, busy, do_data, ld_ready);
        end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0; ld_valid = 1'b0;
    q.delete();
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    do_ready = 1'b1; ld_valid = 1'b1; ld_data = V;
    push_blk(V);
    @(posedge clk); #1 ld_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    e = q.pop_front();
    if (do_valid !== 1'b1 || do_data !== e.d) begin
      n_fail++;
      $display("FAIL rstmid_w0: got %b/%h want 1/%h",
               do_valid, do_data, e.d);
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_chk++;
    if ({do_valid, do_data, do_last, busy} !== 35'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got v%b d%h l%b b%b want all 0",
               do_valid, do_data, do_last, busy);
    end
    q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if (do_valid !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_release: got v%b r%b want v0 r1",
               do_valid, ld_ready);
    end
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_data = A;
    push_blk(A);
    @(posedge clk); #1 ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++;
      e = q.pop_front();
      if (do_valid !== 1'b1 || do_data !== e.d || do_last !== e.l) begin
        n_fail++;
        $display("FAIL rstmid_stream[%0d]: got %b/%h/%b want 1/%h/%b",
                 i, do_valid, do_data, do_last, e.d, e.l);
      end
    end
  endtask

  task automatic test_loopback();
    logic [127:0] v;
    logic [127:0] ldr;
    bit           ok;
    do_ready = 1'b1;
    for (int k = 0; k < 100; k++) begin
      v = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      ld_valid = 1'b1; ld_data = v;
      @(posedge clk); #1 ld_valid = 1'b0;
      ldr = '0;
      ok  = 1'b1;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        if (do_valid !== 1'b1 || do_last !== (i == 3)) ok = 1'b0;
        ldr = {ldr[95:0], do_data};
      end
      n_chk++;
      if (ldr !== v || !ok) begin
        n_fail++;
        $display("FAIL loopback[%0d]: got %h ok%b want %h ok1",
                 k, ldr, ok, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
